// File: rtl/log_compress.sv
// log_compress: iterative base-2 log of FIFO magnitude samples; define LOGC_CLAMP_EN to clamp inputs below MIN_THRESHOLD.
module log_compress #(
    parameter int DATA_WIDTH    = 48,
    parameter int FRAC_WIDTH    = 16,
    parameter int MIN_THRESHOLD = 1,
    parameter int NORM_WIDTH    = FRAC_WIDTH + 1,
    parameter int SHIFT_WIDTH   = $clog2(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   fifo_out_valid,
    output logic                   log_in_ready,
    output logic [SHIFT_WIDTH-1:0] comp_int,
    output logic [NORM_WIDTH-1:0]  comp_frac,
    output logic                   comp_valid
);
    typedef enum logic [2:0] {IDLE, WAIT, NORM, ITER, DONE} state_t;
    localparam int CW = $clog2(FRAC_WIDTH);
    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   x_q, x_d, xc;
    logic [SHIFT_WIDTH-1:0]  k_q, k_d, msb, int_q, int_d;
    logic [NORM_WIDTH-1:0]   m_q, m_d, m_norm, cfrac_q, cfrac_d;
    logic [2*NORM_WIDTH-1:0] me;
    logic [NORM_WIDTH:0]     sqh;
    logic [FRAC_WIDTH-1:0]   frac_q, frac_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    ready_q, ready_d, valid_q, valid_d;

    always_comb begin
`ifdef LOGC_CLAMP_EN
        xc = (x_q < DATA_WIDTH'(MIN_THRESHOLD)) ? DATA_WIDTH'(MIN_THRESHOLD) : x_q;
`else
        xc = x_q;
`endif
        msb = '0;
        for (int i = 0; i < DATA_WIDTH; i++)
            if (xc[i]) msb = SHIFT_WIDTH'(i);
        m_norm = NORM_WIDTH'((xc << (SHIFT_WIDTH'(DATA_WIDTH - 1) - msb)) >> (DATA_WIDTH - NORM_WIDTH));
        me = {{NORM_WIDTH{1'b0}}, m_q};
        // keep only the Q2 bits that can form the next Q1 mantissa
        sqh = (NORM_WIDTH + 1)'((me * me) >> (NORM_WIDTH - 1));
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        k_d     = k_q;
        m_d     = m_q;
        frac_d  = frac_q;
        cnt_d   = cnt_q;
        int_d   = int_q;
        cfrac_d = cfrac_q;
        case (state_q)
            IDLE: state_d = ready_q ? WAIT : IDLE;
            WAIT: begin
                state_d = fifo_out_valid ? NORM : IDLE;
                x_d     = fifo_out_valid ? data_in : x_q;
            end
            NORM: begin
                state_d = ITER;
                k_d     = msb;
                m_d     = m_norm;
                frac_d  = '0;
                cnt_d   = '0;
            end
            ITER: begin
                frac_d  = {frac_q[FRAC_WIDTH-2:0], sqh[NORM_WIDTH]};
                m_d     = sqh[NORM_WIDTH] ? sqh[NORM_WIDTH:1] : sqh[NORM_WIDTH-1:0];
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(FRAC_WIDTH - 1)) ? DONE : ITER;
            end
            default: state_d = IDLE;
        endcase
        ready_d = state_d == IDLE;
        valid_d = state_d == DONE;
        int_d   = valid_d ? k_q : int_d;
        cfrac_d = valid_d ? {1'b0, frac_d} : cfrac_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            k_q     <= '0;
            m_q     <= '0;
            frac_q  <= '0;
            cnt_q   <= '0;
            int_q   <= '0;
            cfrac_q <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            k_q     <= k_d;
            m_q     <= m_d;
            frac_q  <= frac_d;
            cnt_q   <= cnt_d;
            int_q   <= int_d;
            cfrac_q <= cfrac_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign log_in_ready = ready_q;
    assign comp_int     = int_q;
    assign comp_frac    = cfrac_q;
    assign comp_valid   = valid_q;
endmodule

// File: tb/tb_log_compress.sv
// tb_log_compress: directed-vector bench with a read-registered FIFO model in front of log_compress.
module tb_log_compress;
    localparam int DW = 48;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          fifo_out_valid = 1'b0;
    logic          log_in_ready, comp_valid;
    logic [5:0]    comp_int;
    logic [16:0]   comp_frac;
    int n_cmp = 0, n_err = 0, cyc = 0, pops = 0, rdy_cyc = 0;
    logic [DW-1:0] fifo_q[$];
    int res_int[$], res_frac[$], res_cyc[$];

    log_compress dut (
        .clk(clk), .reset(reset), .data_in(data_in), .fifo_out_valid(fifo_out_valid),
        .log_in_ready(log_in_ready), .comp_int(comp_int), .comp_frac(comp_frac), .comp_valid(comp_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO: rd_en seen in cycle N presents data/out_valid throughout cycle N+1
    initial begin
        bit pop;
        forever begin
            @(negedge clk);
            pop = log_in_ready && fifo_q.size() > 0;
            if (pop) rdy_cyc = cyc;
            @(posedge clk);
            #1;
            fifo_out_valid = pop;
            if (pop) begin
                data_in = fifo_q.pop_front();
                pops++;
            end else data_in = '0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (comp_valid) begin
            res_int.push_back(int'(comp_int));
            res_frac.push_back(int'(comp_frac));
            res_cyc.push_back(cyc);
        end
    end

    task automatic check(string tag, longint obs, longint exp, longint tol = 0);
        n_cmp++;
        if (obs > exp + tol || obs < exp - tol) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic get_res(output int ri, output int rf, output int rc);
        for (int t = 0; t < 200 && res_int.size() == 0; t++) @(negedge clk);
        if (res_int.size() == 0) begin
            check("result_timeout", 0, 1);
            ri = -1; rf = -1; rc = -1;
        end else begin
            ri = res_int.pop_front();
            rf = res_frac.pop_front();
            rc = res_cyc.pop_front();
        end
    endtask

    logic [DW-1:0] vals[5] = '{48'd65536, 48'd1, 48'd0, 48'd120362, 48'h8000_0000_0000};
    int ei[5] = '{16, 0, 0, 16, 47};
    int ef[5] = '{0, 0, 0, 57476, 0};
    int tl[5] = '{0, 0, 0, 2, 0};

    initial begin
        int ri, rf, rc, prev, p0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", log_in_ready, 0);
        check("rst_int", comp_int, 0);
        check("rst_frac", comp_frac, 0);
        check("rst_valid", comp_valid, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("ready_before_edge", log_in_ready, 0);
        @(negedge clk);
        check("ready_first", log_in_ready, 1);
        @(negedge clk);
        check("ready_one_cycle", log_in_ready, 0);

        repeat (10) @(negedge clk);
        check("empty_no_valid", res_int.size(), 0);
        check("empty_no_pop", pops, 0);
        check("empty_int", comp_int, 0);

        fifo_q.push_back(48'd3);
        get_res(ri, rf, rc);
        check("x3_int", ri, 1);
        check("x3_frac", rf, 38336, 2);
        check("x3_latency", rc - rdy_cyc, 19);

        p0 = pops;
        foreach (vals[i]) fifo_q.push_back(vals[i]);
        foreach (vals[i]) begin
            get_res(ri, rf, rc);
            check($sformatf("vec%0d_int", i), ri, ei[i]);
            check($sformatf("vec%0d_frac", i), rf, ef[i], tl[i]);
        end
        check("vec_pops", pops - p0, 5);

        p0 = pops;
        prev = 0;
        repeat (4) fifo_q.push_back(48'd987654321);
        for (int i = 0; i < 4; i++) begin
            get_res(ri, rf, rc);
            check($sformatf("cont%0d_int", i), ri, 29);
            check($sformatf("cont%0d_frac", i), rf, 57633, 2);
            if (i > 0) check($sformatf("cont%0d_spacing", i), rc - prev, 20);
            prev = rc;
        end
        check("cont_pops", pops - p0, 4);
        check("frac_msb", comp_frac[16], 0);

        p0 = pops;
        fifo_q.push_back(48'd120362);
        for (int t = 0; t < 50 && pops == p0; t++) @(negedge clk);
        check("rst_mid_popped", pops - p0, 1);
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mid_int", comp_int, 0);
        check("rst_mid_frac", comp_frac, 0);
        check("rst_mid_valid", comp_valid, 0);
        repeat (30) @(negedge clk);
        check("rst_mid_no_valid", res_int.size(), 0);
        fifo_q.push_back(48'd987654321);
        get_res(ri, rf, rc);
        check("post_rst_int", ri, 29);
        check("post_rst_frac", rf, 57633, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/log_compress.md
# log_compress

Log-compression stage of the ultrasound envelope chain. Pulls 48-bit magnitude samples one at a time from an upstream read-registered FIFO and computes base-2 logarithms. The integer part comes from leading-one detection. The fractional part comes from iterative mantissa squaring. Results are registered unsigned log2 values for downstream scan conversion.

## Interface
Parameters:
- DATA_WIDTH, 48, input sample width.
- FRAC_WIDTH, 16, fractional bits of result.
- MIN_THRESHOLD, 1, lower clamp applied to input before log.
- NORM_WIDTH, FRAC_WIDTH+1, normalized mantissa width (Q1.FRAC_WIDTH).
- SHIFT_WIDTH, $clog2(DATA_WIDTH), integer-part width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- data_in  in  DATA_WIDTH  sample from FIFO data_out.
- fifo_out_valid  in  1  data_in valid (FIFO out_valid).
- log_in_ready  out  1  pop request; drives FIFO rd_en.
- comp_int  out  SHIFT_WIDTH  floor(log2(x)).
- comp_frac  out  NORM_WIDTH  fractional log2, unsigned Q1.16, MSB always 0.
- comp_valid  out  1  one-cycle pulse when comp_int/comp_frac update.

## Operation
- FSM states: IDLE, WAIT, NORM, ITER, DONE.
- IDLE:
  - log_in_ready=1 for exactly one cycle.
  - Next state is WAIT.
- WAIT:
  - log_in_ready=0.
  - If fifo_out_valid=1, capture data_in into x and go to NORM.
  - Otherwise (FIFO was empty) return to IDLE.
- NORM:
  - Clamp x per Configuration.
  - comp_int candidate k = index of most-significant 1 of x.
  - Mantissa m = top NORM_WIDTH bits of (x << (DATA_WIDTH-1-k)), truncated.
  - Clear the frac accumulator and the bit counter.
- ITER (FRAC_WIDTH cycles, MSB first):
  - s = m*m (2*NORM_WIDTH bits, Q2.32).
  - If s[2*NORM_WIDTH-1]=1: set frac bit to 1 and m = s[33:17].
  - Else: set frac bit to 0 and m = s[32:16].
- DONE:
  - Register comp_int=k and comp_frac={1'b0, frac}.
  - comp_valid=1.
  - Next state is IDLE.
- Outputs hold their last result until the next DONE.
- Exact powers of two give comp_frac=0 exactly.
- Accuracy of comp_frac versus ideal floor(frac(log2 x)·2^16): within ±2 LSB.

## Timing
- Reset values:
  - FSM=IDLE.
  - log_in_ready=0, comp_int=0, comp_frac=0, comp_valid=0.
- log_in_ready is 0 during reset and rises on the first cycle after reset deasserts.
- FIFO contract: rd_en at cycle N yields data_out/out_valid at N+1.
- Per sample, from the log_in_ready cycle: IDLE(1) + WAIT(1) + NORM(1) + ITER(16) + DONE(1) = 20 cycles.
- comp_valid is asserted 19 cycles after log_in_ready.
- Throughput: one sample per 20 cycles.
- Exactly one FIFO pop per IDLE visit.
- Empty FIFO: WAIT->IDLE loop, 2-cycle retry, outputs unchanged.
- fifo_out_valid outside WAIT is ignored.
- Reset asserted mid-computation: the in-flight sample is discarded, all outputs clear next edge, no comp_valid pulse.

## Configuration
- LOGC_CLAMP_EN defined: x<MIN_THRESHOLD is replaced by MIN_THRESHOLD before NORM.
- LOGC_CLAMP_EN undefined: only x=0 is special-cased to result int=0, frac=0; values below MIN_THRESHOLD are otherwise processed unmodified.
- With the default MIN_THRESHOLD=1, both builds give identical results.

## Test plan
- Reset held 2 cycles, then released: all outputs 0 during reset; log_in_ready=1 on the first post-reset cycle.
- FIFO continuously fed 987654321: comp_int=29, comp_frac=57633±2, comp_valid every 20 cycles; exactly one FIFO pop per result.
- Input 65536 -> comp_int=16, comp_frac=0. Input 1 -> comp_int=0, comp_frac=0. Input 0 -> comp_int=0, comp_frac=0.
- Input 120362 -> comp_int=16, comp_frac=57476±2. Input 2^47 -> comp_int=47, comp_frac=0.
- FIFO empty (out_valid=0) for 10 cycles, then write 3 -> no comp_valid while empty; then comp_int=1, comp_frac=38336±2.
- Reset pulsed during ITER -> no comp_valid; outputs 0; the next sample computes correctly.
